// File: rtl/dm_arb_if.sv
// Bundles the CPU and DBG request ports and the data-memory port of dm_arbiter.
// The slave modport is the arbiter's view. The master modport is the surrounding system's view.
interface dm_arb_if;
  logic        cpu_req;
  logic        cpu_we;
  logic        cpu_sb;
  logic [11:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_gnt;
  logic        cpu_stall;
  logic        cpu_rvalid;
  logic [31:0] cpu_rdata;

  logic        dbg_req;
  logic        dbg_lock;
  logic        dbg_we;
  logic        dbg_sb;
  logic [11:0] dbg_addr;
  logic [31:0] dbg_wdata;
  logic        dbg_gnt;
  logic        dbg_rvalid;
  logic [31:0] dbg_rdata;

  logic [11:0] mem_addr;
  logic [31:0] mem_din;
  logic        mem_we;
  logic        mem_sb;
  logic [31:0] mem_dout;

  modport slave (
    input  cpu_req, cpu_we, cpu_sb, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
    input  dbg_req, dbg_lock, dbg_we, dbg_sb, dbg_addr, dbg_wdata,
    output dbg_gnt, dbg_rvalid, dbg_rdata,
    output mem_addr, mem_din, mem_we, mem_sb,
    input  mem_dout
  );

  modport master (
    output cpu_req, cpu_we, cpu_sb, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata,
    output dbg_req, dbg_lock, dbg_we, dbg_sb, dbg_addr, dbg_wdata,
    input  dbg_gnt, dbg_rvalid, dbg_rdata,
    input  mem_addr, mem_din, mem_we, mem_sb,
    output mem_dout
  );
endinterface

// File: rtl/dm_arbiter.sv
// Data-memory arbiter: the CPU has priority, DBG gets an anti-starvation grant, and DBG can take a bounded burst lock.
// Defining DM_ARB_STATS_EN adds the saturating stat_conflict and stat_force counters.
module dm_arbiter #(
  parameter int unsigned WAIT_MAX = 8,
  parameter int unsigned LOCK_MAX = 16
) (
  input  logic        clk,
  input  logic        rst,
  dm_arb_if.slave     bus
`ifdef DM_ARB_STATS_EN
  ,
  output logic [15:0] stat_conflict,
  output logic [15:0] stat_force
`endif
);

  typedef enum logic {S_NORM, S_LOCK} state_t;

  localparam logic [7:0] WAIT_MAX_C = 8'(WAIT_MAX);
  localparam logic [7:0] LOCK_MAX_C = 8'(LOCK_MAX);

  state_t      state_q, state_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic [7:0]  lock_cnt_q, lock_cnt_d;
  logic        cpu_rvalid_q, dbg_rvalid_q;
  logic [31:0] cpu_rdata_q, dbg_rdata_q;

  logic cpu_gnt, dbg_gnt;
  logic wait_full, lock_last;
  logic force_grant, force_rel;

  assign wait_full = (wait_cnt_q == WAIT_MAX_C);
  // lock_cnt holds the number of locked grants already made, so this is the final permitted grant.
  assign lock_last = (lock_cnt_q == LOCK_MAX_C - 8'd1);

  always_comb begin
    cpu_gnt     = 1'b0;
    dbg_gnt     = 1'b0;
    force_grant = 1'b0;
    force_rel   = 1'b0;
    state_d     = state_q;
    lock_cnt_d  = lock_cnt_q;
    wait_cnt_d  = wait_cnt_q;

    if (!rst) begin
      case (state_q)
        S_NORM: begin
          dbg_gnt     = bus.dbg_req & (~bus.cpu_req | wait_full);
          cpu_gnt     = bus.cpu_req & ~dbg_gnt;
          force_grant = dbg_gnt & bus.cpu_req;
          if (dbg_gnt && bus.dbg_lock && (LOCK_MAX > 1)) begin
            state_d    = S_LOCK;
            lock_cnt_d = 8'd1;
          end
        end
        S_LOCK: begin
          dbg_gnt    = bus.dbg_req;
          lock_cnt_d = lock_cnt_q + 8'd1;
          if (!bus.dbg_lock) begin
            state_d    = S_NORM;
            lock_cnt_d = 8'd0;
          end else if (lock_last) begin
            state_d    = S_NORM;
            lock_cnt_d = 8'd0;
            force_rel  = 1'b1;
          end
        end
        default: state_d = S_NORM;
      endcase

      if (!bus.dbg_req || dbg_gnt || force_rel) begin
        wait_cnt_d = 8'd0;
      end else if (cpu_gnt && !wait_full) begin
        wait_cnt_d = wait_cnt_q + 8'd1;
      end
    end
  end

  always_comb begin
    bus.mem_addr = 12'd0;
    bus.mem_din  = 32'd0;
    bus.mem_we   = 1'b0;
    bus.mem_sb   = 1'b0;
    if (cpu_gnt) begin
      bus.mem_addr = bus.cpu_addr;
      bus.mem_din  = bus.cpu_wdata;
      bus.mem_we   = bus.cpu_we;
      bus.mem_sb   = bus.cpu_sb;
    end else if (dbg_gnt) begin
      bus.mem_addr = bus.dbg_addr;
      bus.mem_din  = bus.dbg_wdata;
      bus.mem_we   = bus.dbg_we;
      bus.mem_sb   = bus.dbg_sb;
    end
  end

  assign bus.cpu_gnt    = cpu_gnt;
  assign bus.dbg_gnt    = dbg_gnt;
  assign bus.cpu_stall  = bus.cpu_req & ~cpu_gnt;
  assign bus.cpu_rvalid = cpu_rvalid_q;
  assign bus.cpu_rdata  = cpu_rdata_q;
  assign bus.dbg_rvalid = dbg_rvalid_q;
  assign bus.dbg_rdata  = dbg_rdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_NORM;
      wait_cnt_q   <= 8'd0;
      lock_cnt_q   <= 8'd0;
      cpu_rvalid_q <= 1'b0;
      dbg_rvalid_q <= 1'b0;
      cpu_rdata_q  <= 32'd0;
      dbg_rdata_q  <= 32'd0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      lock_cnt_q   <= lock_cnt_d;
      cpu_rvalid_q <= cpu_gnt & ~bus.cpu_we;
      dbg_rvalid_q <= dbg_gnt & ~bus.dbg_we;
      if (cpu_gnt && !bus.cpu_we) cpu_rdata_q <= bus.mem_dout;
      if (dbg_gnt && !bus.dbg_we) dbg_rdata_q <= bus.mem_dout;
    end
  end

`ifdef DM_ARB_STATS_EN
  logic [15:0] stat_conflict_q, stat_force_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_conflict_q <= 16'd0;
      stat_force_q    <= 16'd0;
    end else begin
      if (bus.cpu_req && bus.dbg_req && stat_conflict_q != 16'hFFFF)
        stat_conflict_q <= stat_conflict_q + 16'd1;
      if ((force_grant || force_rel) && stat_force_q != 16'hFFFF)
        stat_force_q <= stat_force_q + 16'd1;
    end
  end

  assign stat_conflict = stat_conflict_q;
  assign stat_force    = stat_force_q;
`endif

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter with default parameters and a small behavioural data memory.
// Inputs change on the falling edge, and outputs are sampled 1 ns later.
module tb_dm_arbiter;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_err;

  dm_arb_if bus();

`ifdef DM_ARB_STATS_EN
  logic [15:0] stat_conflict, stat_force;
`endif

  dm_arbiter #(.WAIT_MAX(8), .LOCK_MAX(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef DM_ARB_STATS_EN
    ,
    .stat_conflict (stat_conflict),
    .stat_force    (stat_force)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural data memory: combinational read, write on the rising edge, byte lane selected by addr[1:0].
  logic [31:0] mem [0:1023];
  assign bus.mem_dout = mem[bus.mem_addr[11:2]];
  always @(posedge clk) begin
    if (bus.mem_we) begin
      if (bus.mem_sb)
        mem[bus.mem_addr[11:2]][{bus.mem_addr[1:0], 3'b000} +: 8] <= bus.mem_din[7:0];
      else
        mem[bus.mem_addr[11:2]] <= bus.mem_din;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic next();
    @(negedge clk);
  endtask

  task automatic set_cpu(input logic req, input logic we, input logic [11:0] addr, input logic [31:0] wdata);
    bus.cpu_req   = req;
    bus.cpu_we    = we;
    bus.cpu_sb    = 1'b0;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wdata;
  endtask

  task automatic set_dbg(input logic req, input logic lock, input logic we, input logic sb,
                         input logic [11:0] addr, input logic [31:0] wdata);
    bus.dbg_req   = req;
    bus.dbg_lock  = lock;
    bus.dbg_we    = we;
    bus.dbg_sb    = sb;
    bus.dbg_addr  = addr;
    bus.dbg_wdata = wdata;
  endtask

  initial begin
    n_checks = 0;
    n_err    = 0;

    // Reset: grants must stay low even with both ports requesting.
    rst = 1'b1;
    set_cpu(1'b1, 1'b0, 12'h000, 32'h0);
    set_dbg(1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 32'h0);
    #1;
    chk("rst_cpu_gnt", bus.cpu_gnt, 0);
    chk("rst_dbg_gnt", bus.dbg_gnt, 0);
    chk("rst_cpu_rvalid", bus.cpu_rvalid, 0);
    chk("rst_cpu_rdata", bus.cpu_rdata, 0);
    chk("rst_dbg_rvalid", bus.dbg_rvalid, 0);
    $display("txn reset done");

    // CPU-only write of DEADBEEF to 0x010.
    next();
    rst = 1'b0;
    set_cpu(1'b1, 1'b1, 12'h010, 32'hDEADBEEF);
    set_dbg(1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 32'h0);
    #1;
    chk("wr_cpu_gnt", bus.cpu_gnt, 1);
    chk("wr_cpu_stall", bus.cpu_stall, 0);
    chk("wr_mem_we", bus.mem_we, 1);
    chk("wr_mem_addr", bus.mem_addr, 12'h010);
    chk("wr_mem_din", bus.mem_din, 32'hDEADBEEF);
    $display("txn cpu write 010 <= DEADBEEF");

    // CPU read of 0x010.
    next();
    set_cpu(1'b1, 1'b0, 12'h010, 32'h0);
    #1;
    chk("rd_cpu_gnt", bus.cpu_gnt, 1);
    chk("rd_mem_we", bus.mem_we, 0);
    chk("rd_rvalid_after_wr", bus.cpu_rvalid, 0);

    next();
    set_cpu(1'b0, 1'b0, 12'h000, 32'h0);
    #1;
    chk("rd_cpu_rvalid", bus.cpu_rvalid, 1);
    chk("rd_cpu_rdata", bus.cpu_rdata, 32'hDEADBEEF);
    chk("idle_mem_addr", bus.mem_addr, 0);
    chk("idle_mem_we", bus.mem_we, 0);
    $display("txn cpu read 010 -> %h", bus.cpu_rdata);

    next();
    #1;
    chk("rvalid_one_cycle", bus.cpu_rvalid, 0);
    chk("rdata_hold", bus.cpu_rdata, 32'hDEADBEEF);

    // Contention: eight CPU grants, then one forced DBG grant, repeating.
    next();
    set_cpu(1'b1, 1'b0, 12'h010, 32'h0);
    set_dbg(1'b1, 1'b0, 1'b0, 1'b0, 12'h100, 32'h0);
    for (int i = 0; i < 18; i++) begin
      #1;
      chk($sformatf("cont_dbg_gnt_%0d", i), bus.dbg_gnt, (i % 9) == 8);
      chk($sformatf("cont_cpu_gnt_%0d", i), bus.cpu_gnt, (i % 9) != 8);
      chk($sformatf("cont_stall_%0d", i), bus.cpu_stall, (i % 9) == 8);
      chk($sformatf("cont_dbg_rvalid_%0d", i), bus.dbg_rvalid, (i > 0) && ((i % 9) == 0));
      $display("txn contention cycle %0d cpu_gnt=%0b dbg_gnt=%0b", i, bus.cpu_gnt, bus.dbg_gnt);
      next();
    end

    // DBG byte store of AB to 0x013, followed by a word read of 0x010.
    set_cpu(1'b0, 1'b0, 12'h000, 32'h0);
    set_dbg(1'b1, 1'b0, 1'b1, 1'b1, 12'h013, 32'h000000AB);
    #1;
    chk("sb_dbg_gnt", bus.dbg_gnt, 1);
    chk("sb_mem_sb", bus.mem_sb, 1);
    chk("sb_mem_addr", bus.mem_addr, 12'h013);
    chk("sb_mem_we", bus.mem_we, 1);
    chk("sb_mem_din", bus.mem_din, 32'h000000AB);
    $display("txn dbg byte store 013 <= AB");

    next();
    set_dbg(1'b1, 1'b0, 1'b0, 1'b0, 12'h010, 32'h0);
    #1;
    chk("dbgrd_gnt", bus.dbg_gnt, 1);
    chk("dbgrd_mem_sb", bus.mem_sb, 0);

    // Lock burst with the CPU requesting throughout.
    next();
    set_cpu(1'b1, 1'b0, 12'h010, 32'h0);
    set_dbg(1'b1, 1'b1, 1'b1, 1'b0, 12'h200, 32'h12345678);
    #1;
    chk("dbgrd_rvalid", bus.dbg_rvalid, 1);
    chk("dbgrd_rdata", bus.dbg_rdata, 32'hABADBEEF);
    $display("txn dbg read 010 -> %h", bus.dbg_rdata);
    for (int i = 0; i < 26; i++) begin
      if (i > 0) #1;
      chk($sformatf("lock_dbg_gnt_%0d", i), bus.dbg_gnt, (i >= 8) && (i <= 23));
      chk($sformatf("lock_cpu_gnt_%0d", i), bus.cpu_gnt, !((i >= 8) && (i <= 23)));
      $display("txn lock cycle %0d cpu_gnt=%0b dbg_gnt=%0b", i, bus.cpu_gnt, bus.dbg_gnt);
      next();
    end

    // Early unlock after three locked cycles.
    set_cpu(1'b0, 1'b0, 12'h000, 32'h0);
    set_dbg(1'b1, 1'b1, 1'b1, 1'b0, 12'h204, 32'h0);
    #1;
    chk("eu_entry_dbg_gnt", bus.dbg_gnt, 1);
    for (int i = 0; i < 3; i++) begin
      next();
      set_cpu(1'b1, 1'b0, 12'h010, 32'h0);
      #1;
      chk($sformatf("eu_lock_dbg_gnt_%0d", i), bus.dbg_gnt, 1);
      chk($sformatf("eu_lock_cpu_gnt_%0d", i), bus.cpu_gnt, 0);
      chk($sformatf("eu_lock_stall_%0d", i), bus.cpu_stall, 1);
      $display("txn early-unlock locked cycle %0d", i);
    end
    next();
    set_dbg(1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 32'h0);
    #1;
    chk("eu_release_cpu_gnt", bus.cpu_gnt, 0);
    chk("eu_release_dbg_gnt", bus.dbg_gnt, 0);
    next();
    #1;
    chk("eu_after_cpu_gnt", bus.cpu_gnt, 1);
    $display("txn early unlock, cpu granted");

    // Reset asserted mid-lock with a DBG read in flight.
    next();
    set_cpu(1'b0, 1'b0, 12'h000, 32'h0);
    set_dbg(1'b1, 1'b1, 1'b0, 1'b0, 12'h010, 32'h0);
    #1;
    chk("rl_entry_dbg_gnt", bus.dbg_gnt, 1);
    chk("rl_cpu_rvalid", bus.cpu_rvalid, 1);
    next();
    #1;
    chk("rl_lock_dbg_gnt", bus.dbg_gnt, 1);
    chk("rl_dbg_rvalid", bus.dbg_rvalid, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("rl_rst_dbg_gnt", bus.dbg_gnt, 0);
    chk("rl_rst_cpu_gnt", bus.cpu_gnt, 0);
    chk("rl_rst_dbg_rvalid", bus.dbg_rvalid, 0);
    chk("rl_rst_dbg_rdata", bus.dbg_rdata, 0);
    $display("txn reset mid-lock");
    next();
    rst = 1'b0;
    set_cpu(1'b1, 1'b0, 12'h010, 32'h0);
    set_dbg(1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 32'h0);
    #1;
    chk("rl_post_cpu_gnt", bus.cpu_gnt, 1);
    chk("rl_post_dbg_gnt", bus.dbg_gnt, 0);
    next();
    set_cpu(1'b0, 1'b0, 12'h000, 32'h0);
    #1;
    chk("rl_post_cpu_rvalid", bus.cpu_rvalid, 1);
    chk("rl_post_cpu_rdata", bus.cpu_rdata, 32'hABADBEEF);
    chk("rl_post_dbg_rvalid", bus.dbg_rvalid, 0);
    $display("txn cpu read after reset -> %h", bus.cpu_rdata);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/dm_arbiter.md
Name: dm_arbiter

Overview:
- Shares the single-port 4 KB data memory between two requesters: the pipeline MEM stage (CPU port) and a debug/loader port (DBG port).
- Sits between the MEM stage, the debug loader and the data memory.
- Presents one access per cycle to the memory and stalls the losing requester.
- Returns read data one cycle after grant, and supports a locked DBG burst for bulk program/data loading.

Parameters:
- WAIT_MAX, 8, max consecutive cycles DBG may wait while CPU is granted before DBG is forced a grant (1..255).
- LOCK_MAX, 16, max consecutive cycles DBG may hold a lock before the lock is force-released (1..255).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- cpu_req  in  1  CPU access request (held until granted)
- cpu_we  in  1  CPU write enable
- cpu_sb  in  1  CPU byte store (valid with cpu_we)
- cpu_addr  in  12  CPU byte address
- cpu_wdata  in  32  CPU write data
- cpu_gnt  out  1  CPU granted this cycle (combinational)
- cpu_stall  out  1  cpu_req & ~cpu_gnt, to hazard unit
- cpu_rvalid  out  1  CPU read data valid (registered)
- cpu_rdata  out  32  CPU read data (registered)
- dbg_req  in  1  DBG access request
- dbg_lock  in  1  DBG requests burst lock
- dbg_we  in  1  DBG write enable
- dbg_sb  in  1  DBG byte store
- dbg_addr  in  12  DBG byte address
- dbg_wdata  in  32  DBG write data
- dbg_gnt  out  1  DBG granted this cycle (combinational)
- dbg_rvalid  out  1  DBG read data valid (registered)
- dbg_rdata  out  32  DBG read data (registered)
- mem_addr  out  12  address to data memory
- mem_din  out  32  write data to data memory
- mem_we  out  1  write enable to data memory
- mem_sb  out  1  byte-store select to data memory
- mem_dout  in  32  data memory combinational read data

Behaviour:
- Reset (async, rst=1):
  - state=S_NORM, wait_cnt=0, lock_cnt=0.
  - cpu_rvalid=dbg_rvalid=0, cpu_rdata=dbg_rdata=0.
  - Grants are 0 while rst is high.
- Grant rules:
  - At most one grant per cycle; a grant is only asserted with its req.
  - S_NORM: CPU has priority. dbg_gnt=dbg_req & (~cpu_req | wait_cnt==WAIT_MAX); otherwise cpu_gnt=cpu_req.
  - S_LOCK: dbg_gnt=dbg_req and cpu_gnt=0, even if cpu_req=1.
- Memory mux:
  - mem_addr/mem_din/mem_sb come from the granted port.
  - mem_we = granted port's we.
  - With no grant: mem_we=0, mem_addr=0, mem_din=0, mem_sb=0.
  - Write commits at the memory on the same rising edge.
- Read return:
  - A granted read (we=0) captures mem_dout into that port's rdata at the edge.
  - That port's rvalid is then 1 for exactly the next cycle.
  - A granted write gives rvalid=0. rdata holds its value when not updated.
- wait_cnt:
  - Increments when dbg_req=1 and cpu_gnt=1 (saturating at WAIT_MAX).
  - Clears to 0 on any dbg_gnt or when dbg_req=0.
- FSM:
  - S_NORM -> S_LOCK when dbg_gnt & dbg_lock. lock_cnt is set to 1.
  - S_LOCK: lock_cnt increments each cycle.
  - S_LOCK -> S_NORM when dbg_lock=0, or when lock_cnt==LOCK_MAX (forced release). On forced release wait_cnt clears.
  - After a forced release, the next cycle follows S_NORM rules. CPU wins if requesting, and DBG cannot re-enter S_LOCK until it is granted again.
- Simultaneous events:
  - Forced release and a new dbg_lock in the same cycle: the release wins.
  - rst mid-lock: return to S_NORM immediately. Any read in flight is dropped, with no rvalid.
- Address handling: passed through unmodified. Byte lanes are selected by the memory from addr[1:0].

Optional Feature:
- DM_ARB_STATS_EN defined: adds outputs stat_conflict[15:0] and stat_force[15:0], both reset to 0 and saturating at 16'hFFFF.
  - stat_conflict counts cycles with cpu_req & dbg_req.
  - stat_force counts forced DBG grants (wait_cnt==WAIT_MAX) plus forced lock releases.
- DM_ARB_STATS_EN undefined: these ports and counters are absent. All other behaviour is identical.

Test Plan:
- CPU only:
  - cpu_req=1, we=1, addr=12'h010, wdata=32'hDEADBEEF -> cpu_gnt=1, mem_we=1, no stall.
  - Next cycle read of 12'h010 -> cpu_rvalid=1 the cycle after, cpu_rdata=32'hDEADBEEF.
- Contention with defaults:
  - cpu_req and dbg_req held high -> CPU granted 8 cycles, dbg_gnt=1 on the 9th cycle with cpu_stall=1 that cycle.
  - Pattern then repeats.
- Byte store via DBG: dbg_we=1, dbg_sb=1, addr=12'h013, wdata=32'h000000AB -> mem_sb=1, mem_addr=12'h013.
- Lock burst with LOCK_MAX=16:
  - dbg_lock=1 with cpu_req held -> exactly 16 consecutive dbg_gnt cycles.
  - Then cpu_gnt=1 on the next cycle.
- Early unlock: dbg_lock drops after 3 locked cycles -> state returns to S_NORM and CPU is granted on the next cycle.
- Reset mid-lock:
  - Assert rst asynchronously during S_LOCK with a read in flight -> gnts=0 immediately, rvalid=0, rdata=0.
  - After release, CPU request is granted at once.
